ripple_counter_ctrl: RTL and testbench

- Sequencer that owns an external 12-stage negative-edge ripple counter (HC4040-class part).
- Drives the counter's clock and clear pins from a single system clock.
- Counts a programmable number of edges, then reports done. Supports one-shot and auto-reload (periodic divider) modes.
- Reads back the counter's Q outputs and checks them against an internal shadow count to detect ripple/wiring faults.

---
 rtl/ripple_counter_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ripple_counter_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_counter_ctrl.sv
// ---------------------------------------------------------------------------
// ripple_counter_ctrl
//
// Sequencer for an external negative-edge ripple counter (HC4040 class).
// It generates the counter clock and clear pins from the system clock and
// counts a programmable number of edges. The part's Q outputs are read back
// and compared with an internal shadow count after each edge has settled.
// Two modes are supported: one-shot, and auto-reload (periodic divider).
//
// Parameters
//   WIDTH      counter stage count (width of tc_in, q_in, count_out)
//   SETTLE     extra low cycles after each falling edge before q_in is
//              compared (0..15)
//   CLR_CYCLES cycles cnt_clr is held high per clear (1..15)
//
// Ports
//   p10         system clock, rising edge
//   p11         asynchronous active-high reset
//   start       run request, sampled only while idle
//   stop        abort, honoured in any non-idle state
//   auto_reload 1 = periodic, 0 = one-shot (latched on start)
//   tc_in       terminal edge count, 0 = 2^WIDTH edges (latched on start)
//   q_in        counter Q readback, Q1 = bit 0
//   cnt_clk     counter clock pin; the counter advances on 1->0
//   cnt_clr     counter asynchronous clear pin, active high
//   busy        high while clearing or counting
//   done        one-cycle pulse at terminal count
//   err         sticky readback mismatch flag
//   count_out   shadow count of edges issued since the last clear
//
// Every output is a flop loaded from the next-state decode, so the outputs
// have no combinational path from any input.
// ---------------------------------------------------------------------------
module ripple_counter_ctrl #(
    parameter int WIDTH      = 12,
    parameter int SETTLE     = 2,
    parameter int CLR_CYCLES = 1
) (
    input  logic             p10,
    input  logic             p11,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] tc_in,
    input  logic [WIDTH-1:0] q_in,
    output logic             cnt_clk,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] count_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN_LO,
        S_RUN_HI,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [3:0] CLR_LAST    = 4'(CLR_CYCLES - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

    state_t           state, state_nx;
    logic [3:0]       cyc, cyc_nx;
    logic [WIDTH-1:0] tc_lat, tc_nx;
    logic             ar_lat, ar_nx;
    logic [WIDTH-1:0] count_nx;
    logic             err_nx;
    logic             clk_nx, clr_nx, busy_nx, done_nx;

    // Next-state, latch and shadow-count logic
    always_comb begin
        state_nx = state;
        cyc_nx   = '0;
        tc_nx    = tc_lat;
        ar_nx    = ar_lat;
        count_nx = count_out;
        err_nx   = err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    tc_nx    = tc_in;
                    ar_nx    = auto_reload;
                    err_nx   = 1'b0;
                    state_nx = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (cyc == CLR_LAST) begin
                    state_nx = S_RUN_LO;
                end else begin
                    cyc_nx = cyc + 4'd1;
                end
            end
            S_RUN_LO: begin
                // Last low cycle: the ripple has settled, check the readback.
                // A terminal count of 0 is reached when the shadow count wraps.
                if (cyc == SETTLE_LAST) begin
                    if (q_in != count_out) begin
                        state_nx = S_ERR;
                    end else if (count_out == tc_lat) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_RUN_HI;
                    end
                end else begin
                    cyc_nx = cyc + 4'd1;
                end
            end
            S_RUN_HI: state_nx = S_RUN_LO;
            S_DONE:   state_nx = ar_lat ? S_CLEAR : S_IDLE;
            S_ERR:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase

        // Abort overrides the compare result and the auto-reload decision.
        if (stop && (state == S_CLEAR || state == S_RUN_LO ||
                     state == S_RUN_HI || state == S_DONE)) begin
            state_nx = S_IDLE;
            cyc_nx   = '0;
        end

        // Shadow count tracks the external part: zero while clearing, and
        // one step on every cycle that drives the clock pin low.
        if (state_nx == S_CLEAR && state != S_CLEAR) begin
            count_nx = '0;
        end else if (state_nx == S_RUN_LO && state != S_RUN_LO) begin
            count_nx = count_out + WIDTH'(1);
        end

        if (state_nx == S_ERR) begin
            err_nx = 1'b1;
        end
    end

    // Pin and status decode of the state being entered
    always_comb begin
        clk_nx  = 1'b1;
        clr_nx  = 1'b0;
        busy_nx = 1'b0;
        done_nx = 1'b0;
        case (state_nx)
            S_IDLE:   clr_nx = 1'b1;
            S_CLEAR: begin
                clr_nx  = 1'b1;
                busy_nx = 1'b1;
            end
            S_RUN_LO: begin
                clk_nx  = 1'b0;
                busy_nx = 1'b1;
            end
            S_RUN_HI: busy_nx = 1'b1;
            S_DONE:   done_nx = 1'b1;
            S_ERR:    clr_nx  = 1'b0;
            default:  clr_nx  = 1'b1;
        endcase
    end

    always_ff @(posedge p10 or posedge p11) begin
        if (p11) begin
            state     <= S_IDLE;
            cyc       <= '0;
            tc_lat    <= '0;
            ar_lat    <= 1'b0;
            count_out <= '0;
            err       <= 1'b0;
            cnt_clk   <= 1'b1;
            cnt_clr   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cyc       <= cyc_nx;
            tc_lat    <= tc_nx;
            ar_lat    <= ar_nx;
            count_out <= count_nx;
            err       <= err_nx;
            cnt_clk   <= clk_nx;
            cnt_clr   <= clr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

endmodule

// File: tb/tb_ripple_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ripple_counter_ctrl
//
// Directed bench for ripple_counter_ctrl with a behavioural HC4040 model
// (async clear, advance on clock fall, optional Q6 stuck-at-0 fault).
// Expected done-pulse cycles are queued when a start is driven and compared
// by a monitor whenever the DUT pulses done.
// ---------------------------------------------------------------------------
module tb_ripple_counter_ctrl;

    localparam int W  = 12;
    localparam int ST = 2;
    localparam int CC = 1;

    logic         p10 = 1'b0;
    logic         p11 = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         auto_reload = 1'b0;
    logic [W-1:0] tc_in = '0;
    logic [W-1:0] q_in;
    logic         cnt_clk, cnt_clr, busy, done, err;
    logic [W-1:0] count_out;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;
    int exp_q[$];

    // External counter model
    logic [W-1:0] mcnt = '0;
    logic         prev_clk = 1'b1;
    int           edges = 0;
    logic         fault = 1'b0;

    ripple_counter_ctrl #(.WIDTH(W), .SETTLE(ST), .CLR_CYCLES(CC)) dut (
        .p10(p10), .p11(p11), .start(start), .stop(stop),
        .auto_reload(auto_reload), .tc_in(tc_in), .q_in(q_in),
        .cnt_clk(cnt_clk), .cnt_clr(cnt_clr), .busy(busy), .done(done),
        .err(err), .count_out(count_out)
    );

    always #5 p10 = ~p10;

    always @(posedge p10) cyc_n <= cyc_n + 1;

    assign q_in = fault ? (mcnt & ~(W'(1) << 5)) : mcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pins are stable mid-cycle; detect clock falls there.
    always @(negedge p10) begin
        if (cnt_clr === 1'b1) begin
            mcnt <= '0;
        end else if (prev_clk === 1'b1 && cnt_clk === 1'b0) begin
            mcnt <= mcnt + W'(1);
        end
        if (prev_clk === 1'b1 && cnt_clk === 1'b0) begin
            edges <= edges + 1;
            if (cnt_clr === 1'b1) chk("fall_during_clear", 1, 0);
        end
        prev_clk <= cnt_clk;
    end

    // Scoreboard: every done pulse must match the next queued cycle.
    always @(negedge p10) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
            else chk("done_cycle", cyc_n, exp_q.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_until_cyc(input int target);
        while (cyc_n < target) @(negedge p10);
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge p10);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    // Drive a start at a negedge; returns the accept-edge cycle number.
    task automatic drive_start(input logic [W-1:0] tc, input logic ar,
                               input int lat, output int acc);
        tc_in       = tc;
        auto_reload = ar;
        start       = 1'b1;
        acc         = cyc_n + 1;
        if (lat > 0) exp_q.push_back(acc + lat);
        @(negedge p10);
        start = 1'b0;
    endtask

    initial begin
        int a;
        int e0;

        // Reset and idle
        #1 p11 = 1'b1;
        #1;
        chk("rst_clk", cnt_clk, 1);
        chk("rst_clr", cnt_clr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count_out, 0);
        repeat (2) @(negedge p10);
        p11 = 1'b0;
        repeat (3) @(negedge p10);
        chk("idle_clr", cnt_clr, 1);
        chk("idle_clk", cnt_clk, 1);
        chk("idle_busy", busy, 0);
        chk("idle_count", count_out, 0);

        // One-shot, 3 edges: done 1 + 2*4 + 3 = 12 cycles after accept
        e0 = edges;
        drive_start(12'd3, 1'b0, 12, a);
        chk("os_busy", busy, 1);
        chk("os_clr_hi", cnt_clr, 1);
        wait_done(40, "os");
        chk("os_edges", edges - e0, 3);
        chk("os_count", count_out, 3);
        chk("os_busy_at_done", busy, 0);
        @(negedge p10);
        chk("os_idle_clr", cnt_clr, 1);
        chk("os_idle_busy", busy, 0);
        chk("os_hold_count", count_out, 3);
        chk("os_sb_empty", exp_q.size(), 0);

        // Auto-reload, tc=2: first done at +8, then every 9 cycles
        drive_start(12'd2, 1'b1, 0, a);
        exp_q.push_back(a + 8);
        exp_q.push_back(a + 17);
        exp_q.push_back(a + 26);
        wait_until_cyc(a + 27);
        chk("ar_reclear", cnt_clr, 1);
        chk("ar_reclear_count", count_out, 0);
        wait_until_cyc(a + 31);
        chk("ar_in_run_hi_clk", cnt_clk, 1);
        chk("ar_in_run_hi_busy", busy, 1);
        stop = 1'b1;
        @(negedge p10);
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_clr", cnt_clr, 1);
        chk("stop_clk", cnt_clk, 1);
        chk("stop_count", count_out, 1);
        repeat (30) @(negedge p10);
        chk("ar_sb_empty", exp_q.size(), 0);

        // tc=0: 4096 edges, done at 1 + 4095*4 + 3 cycles
        e0 = edges;
        drive_start(12'd0, 1'b0, 1 + 4095 * 4 + 3, a);
        wait_done(20000, "wrap");
        chk("wrap_count", count_out, 0);
        chk("wrap_q", q_in, 0);
        chk("wrap_edges", edges - e0, 4096);
        @(negedge p10);
        chk("wrap_sb_empty", exp_q.size(), 0);

        // Q6 stuck at 0: mismatch at the compare after edge 32
        fault = 1'b1;
        drive_start(12'd40, 1'b0, 0, a);
        wait_until_cyc(a + 127);
        chk("flt_err_before", err, 0);
        chk("flt_busy_before", busy, 1);
        @(negedge p10);
        chk("flt_err", err, 1);
        chk("flt_busy", busy, 0);
        chk("flt_done", done, 0);
        chk("flt_count", count_out, 32);
        @(negedge p10);
        chk("flt_idle_clr", cnt_clr, 1);
        chk("flt_err_sticky", err, 1);
        fault = 1'b0;
        repeat (3) @(negedge p10);
        drive_start(12'd1, 1'b0, 4, a);
        chk("flt_err_cleared", err, 0);
        wait_done(20, "flt_restart");
        @(negedge p10);

        // Async reset in RUN_LO at count 7
        drive_start(12'd20, 1'b0, 0, a);
        wait_until_cyc(a + 26);
        chk("mid_clk_low", cnt_clk, 0);
        chk("mid_count7", count_out, 7);
        #1 p11 = 1'b1;
        #1;
        chk("arst_clk", cnt_clk, 1);
        chk("arst_clr", cnt_clr, 1);
        chk("arst_count", count_out, 0);
        chk("arst_busy", busy, 0);
        tc_in = 12'd2;
        auto_reload = 1'b0;
        start = 1'b1;
        @(negedge p10);
        chk("arst_start_held", busy, 0);
        p11 = 1'b0;
        exp_q.push_back(cyc_n + 1 + 8);
        #1;
        chk("arst_release_busy", busy, 0);
        @(negedge p10);
        start = 1'b0;
        chk("arst_accept_busy", busy, 1);
        wait_done(30, "arst");
        repeat (2) @(negedge p10);
        chk("end_sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
